// File: rtl/mmio_arbiter.sv
// Two-requester arbiter for the game register port: CPU read/write, VGA fetch read-only.
// Optional grant/conflict statistics are compiled in with `define ARB_STATS_EN.
module mmio_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [31:0]       vga_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
`ifdef ARB_STATS_EN
  ,output logic [15:0]       cpu_grant_cnt,
   output logic [15:0]       vga_grant_cnt,
   output logic [15:0]       conflict_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StOwnCpu, StOwnVga} state_e;

   localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

   state_e      st_q, st_d;
   logic [3:0]  wait_q, wait_d;
   logic        cpu_rvalid_q, cpu_rvalid_d;
   logic        vga_rvalid_q, vga_rvalid_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d;
   logic [31:0] vga_rdata_q, vga_rdata_d;
   logic        cpu_elig, vga_elig;

   // Grants are a decode of the state register, so they are registered and one cycle long.
   assign cpu_gnt    = (st_q == StOwnCpu);
   assign vga_gnt    = (st_q == StOwnVga);
   assign cpu_rvalid = cpu_rvalid_q;
   assign vga_rvalid = vga_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign vga_rdata  = vga_rdata_q;

   always_comb begin
      // The owner's req during its grant belongs to the access being served.
      cpu_elig = cpu_req && (st_q != StOwnCpu);
      vga_elig = vga_req && (st_q != StOwnVga);

      st_d = StIdle;
      if (cpu_elig && vga_elig) begin
         st_d = (wait_q == MaxWaitC) ? StOwnVga : StOwnCpu;
      end else if (cpu_elig) begin
         st_d = StOwnCpu;
      end else if (vga_elig) begin
         st_d = StOwnVga;
      end

      wait_d = 4'd0;
      if (!vga_gnt && vga_req) begin
         wait_d = (wait_q == MaxWaitC) ? wait_q : wait_q + 4'd1;
      end

      cpu_rvalid_d = cpu_gnt;
      vga_rvalid_d = vga_gnt;
      cpu_rdata_d  = cpu_gnt ? mem_rd : cpu_rdata_q;
      vga_rdata_d  = vga_gnt ? mem_rd : vga_rdata_q;
   end

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = 32'd0;
      unique case (st_q)
         StOwnCpu: begin
            mem_we = cpu_we;
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
         end
         StOwnVga: begin
            mem_a = vga_addr;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= StIdle;
         wait_q       <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         vga_rvalid_q <= 1'b0;
         cpu_rdata_q  <= 32'd0;
         vga_rdata_q  <= 32'd0;
      end else begin
         st_q         <= st_d;
         wait_q       <= wait_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vga_rvalid_q <= vga_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         vga_rdata_q  <= vga_rdata_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] cpu_cnt_q, cpu_cnt_d;
   logic [15:0] vga_cnt_q, vga_cnt_d;
   logic [15:0] conf_cnt_q, conf_cnt_d;

   always_comb begin
      cpu_cnt_d  = cpu_gnt ? cpu_cnt_q + 16'd1 : cpu_cnt_q;
      vga_cnt_d  = vga_gnt ? vga_cnt_q + 16'd1 : vga_cnt_q;
      conf_cnt_d = (cpu_elig && vga_elig) ? conf_cnt_q + 16'd1 : conf_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_cnt_q  <= 16'd0;
         vga_cnt_q  <= 16'd0;
         conf_cnt_q <= 16'd0;
      end else begin
         cpu_cnt_q  <= cpu_cnt_d;
         vga_cnt_q  <= vga_cnt_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   assign cpu_grant_cnt = cpu_cnt_q;
   assign vga_grant_cnt = vga_cnt_q;
   assign conflict_cnt  = conf_cnt_q;
`endif

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: requester tasks push expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_mmio_arbiter;

   localparam int unsigned MaxWait = 4;
   localparam int unsigned AddrW   = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AddrW-1:0] cpu_addr = '0;
   logic [31:0]      cpu_wdata = '0;
   logic             cpu_gnt, cpu_rvalid;
   logic [31:0]      cpu_rdata;
   logic             vga_req = 1'b0;
   logic [AddrW-1:0] vga_addr = '0;
   logic             vga_gnt, vga_rvalid;
   logic [31:0]      vga_rdata;
   logic             mem_we;
   logic [AddrW-1:0] mem_a;
   logic [31:0]      mem_wd, mem_rd;

   int errs = 0;
   int checks = 0;
   logic [31:0] cpu_q[$];
   logic [31:0] vga_q[$];

   mmio_arbiter #(.MAX_WAIT(MaxWait), .ADDR_W(AddrW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Register-map model: word i starts at 0x122+i, written once init is done.
   logic [31:0] regs [16];
   logic        mem_init = 1'b0;
   assign mem_rd = regs[mem_a[5:2]];
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'h122 + 32'(i);
         mem_init <= 1'b1;
      end else if (mem_we) begin
         regs[mem_a[5:2]] <= mem_wd;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("mem_we_outside_cpu_gnt", {31'd0, mem_we & ~cpu_gnt}, 32'd0);
         if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
               checks++; errs++;
               $display("FAIL cpu_rvalid_unexpected: got rdata %h expected no rvalid", cpu_rdata);
            end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
         end
         if (vga_rvalid) begin
            if (vga_q.size() == 0) begin
               checks++; errs++;
               $display("FAIL vga_rvalid_unexpected: got rdata %h expected no rvalid", vga_rdata);
            end else chk("vga_rdata", vga_rdata, vga_q.pop_front());
         end
      end
   end

   // Issue one CPU access at posedge+1; waits counts negedges seen before the grant.
   task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input int lo, input int hi);
      int waits = 0;
      cpu_q.push_back(exp_rd);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      while (1) begin
         @(negedge clk);
         if (cpu_gnt) break;
         waits++;
         if (waits > 20) begin
            checks++; errs++;
            $display("FAIL cpu_gnt_timeout: got no grant expected grant within 20 cycles");
            cpu_req = 1'b0;
            return;
         end
      end
      chk("cpu_mem_a", mem_a, addr);
      chk("cpu_mem_we", {31'd0, mem_we}, {31'd0, we});
      if (we) chk("cpu_mem_wd", mem_wd, wdata);
      chk_range("cpu_latency", waits, lo, hi);
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic vga_access(input logic [31:0] addr, input logic [31:0] exp_rd,
                             input int lo, input int hi);
      int waits = 0;
      vga_q.push_back(exp_rd);
      vga_addr = addr; vga_req = 1'b1;
      while (1) begin
         @(negedge clk);
         if (vga_gnt) break;
         waits++;
         if (waits > 20) begin
            checks++; errs++;
            $display("FAIL vga_gnt_timeout: got no grant expected grant within 20 cycles");
            vga_req = 1'b0;
            return;
         end
      end
      chk("vga_mem_a", mem_a, addr);
      chk("vga_mem_we", {31'd0, mem_we}, 32'd0);
      chk("vga_mem_wd", mem_wd, 32'd0);
      chk_range("vga_latency", waits, lo, hi);
      @(posedge clk); #1;
      vga_req = 1'b0;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_cpu_gnt"}, {31'd0, cpu_gnt}, 32'd0);
      chk({name, "_vga_gnt"}, {31'd0, vga_gnt}, 32'd0);
      chk({name, "_mem_a"}, mem_a, 32'd0);
   endtask

   initial begin
      #2;
      chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("rst_vga_gnt", {31'd0, vga_gnt}, 32'd0);
      chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst_vga_rvalid", {31'd0, vga_rvalid}, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_vga_rdata", vga_rdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Isolated CPU write, then bus returns to idle.
      @(posedge clk); #1;
      cpu_access(1'b1, 32'h1014, 32'h42, 32'h127, 1, 1);
      @(negedge clk);
      chk_idle("after_cpu_write");

      // Isolated VGA read and CPU readback of the write.
      @(posedge clk); #1;
      vga_access(32'h1004, 32'h123, 1, 1);
      cpu_access(1'b0, 32'h1014, 32'h0, 32'h42, 1, 1);
      repeat (2) @(posedge clk); #1;

      // Contention: both streams start together, CPU first, then strict alternation.
      fork
         begin
            cpu_access(1'b1, 32'h1008, 32'hAAAA_0001, 32'h124, 1, 1);
            cpu_access(1'b0, 32'h1008, 32'h0, 32'hAAAA_0001, 1, 1);
            cpu_access(1'b1, 32'h100C, 32'h55, 32'h125, 1, 1);
            cpu_access(1'b0, 32'h100C, 32'h0, 32'h55, 1, 1);
         end
         begin
            vga_access(32'h1000, 32'h122, 2, 2);
            vga_access(32'h1010, 32'h126, 1, 1);
            vga_access(32'h1018, 32'h128, 1, 1);
            vga_access(32'h1004, 32'h123, 1, 1);
         end
      join
      repeat (2) @(posedge clk); #1;

      // Starvation guard: VGA arrives mid CPU stream and must win within MAX_WAIT+1.
      fork
         begin
            for (int i = 0; i < 5; i++) cpu_access(1'b0, 32'h1000, 32'h0, 32'h122, 1, 1);
         end
         begin
            repeat (3) @(posedge clk); #1;
            vga_access(32'h1008, 32'hAAAA_0001, 1, MaxWait + 1);
         end
      join
      repeat (3) @(posedge clk); #1;

      // Reset during a CPU write grant: write discarded, no rvalid, reissue served.
      cpu_we = 1'b1; cpu_addr = 32'h101C; cpu_wdata = 32'h77; cpu_req = 1'b1;
      for (int i = 0; i < 20 && !cpu_gnt; i++) @(negedge clk);
      chk("pre_reset_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("reset_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("reset_cpu_rdata", cpu_rdata, 32'd0);
      chk("reset_vga_rdata", vga_rdata, 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      cpu_access(1'b1, 32'h101C, 32'h77, 32'h129, 1, 1);
      cpu_access(1'b0, 32'h101C, 32'h0, 32'h77, 1, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      chk("vga_q_drained", 32'(vga_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got no finish expected finish before 50000");
      $fatal(1, "timeout");
   end

endmodule
